// File: rtl/cpu_pkg.sv
// Shared CPU constants and the next-PC tracker state encoding.
package cpu_pkg;

    localparam logic [6:0]  OPC_BRANCH         = 7'b1100011;
    localparam int unsigned DEFAULT_PC_W       = 64;
    localparam int unsigned DEFAULT_INST_BYTES = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_RUN     = 2'd1,
        ST_FLUSHED = 2'd2
    } npc_state_e;

endpackage

// File: rtl/if_id_pred_reg.sv
// IF->ID slot carrying the fetch PC and its prediction; the valid bit drops for one
// advance when the instruction being captured is on the wrong path.
module if_id_pred_reg #(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            enable,
    input  logic            flush,
    input  logic [PC_W-1:0] if_pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    output logic [PC_W-1:0] id_pc,
    output logic            id_pred_taken,
    output logic [PC_W-1:0] id_pred_target,
    output logic            id_valid
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
        logic            valid;
    } slot_t;

    slot_t slot_d;
    slot_t slot_q;

    always_comb begin
        // NOTE: default-assign first so every path drives slot_d and no latch is inferred.
        slot_d = slot_q;
        if (enable) begin
            slot_d.pc          = if_pc;
            slot_d.pred_taken  = pred_taken;
            slot_d.pred_target = pred_target;
            slot_d.valid       = ~flush;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (arst) slot_q <= '0;
        else      slot_q <= slot_d;
    end

    assign id_pc          = slot_q.pc;
    assign id_pred_taken  = slot_q.pred_taken;
    assign id_pred_target = slot_q.pred_target;
    assign id_valid       = slot_q.valid;

endmodule

// File: rtl/next_pc_unit.sv
// IF-stage next-PC generator: steers fetch from the table prediction, resolves the
// branch in ID, redirects and flushes on mispredict, and counts branch statistics.
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W       = DEFAULT_PC_W,
    parameter int unsigned     INST_BYTES = DEFAULT_INST_BYTES,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            enable,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic            id_is_branch,
    input  logic            id_taken,
    input  logic [PC_W-1:0] id_target,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic            flush,
    output logic            bp_update,
    output logic            bp_branched,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(INST_BYTES);

    logic [PC_W-1:0] if_pc_d, if_pc_q;
    logic [31:0]     branch_count_d, branch_count_q;
    logic [31:0]     mispredict_count_d, mispredict_count_q;
    logic            id_pred_taken;
    logic [PC_W-1:0] id_pred_target;
    logic            resolve;
    logic            mispredict;
    npc_state_e      state_q;

    if_id_pred_reg #(.PC_W(PC_W)) u_id_slot (
        .clk            (clk),
        .arst           (arst),
        .enable         (enable),
        .flush          (mispredict),
        .if_pc          (if_pc_q),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .id_valid       (id_valid)
    );

    // A taken branch predicted taken to the wrong place is as wrong as a bad direction.
    assign resolve    = id_valid & id_is_branch & enable;
    assign mispredict = resolve & ((id_pred_taken != id_taken) |
                                   (id_taken & id_pred_taken & (id_pred_target != id_target)));

    always_comb begin
        if_pc_d            = if_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (enable) begin
            if (mispredict)      if_pc_d = id_taken ? id_target : id_pc + PC_INC;
            else if (pred_taken) if_pc_d = pred_target;
            else                 if_pc_d = if_pc_q + PC_INC;
            branch_count_d     = branch_count_q + 32'(resolve);
            mispredict_count_d = mispredict_count_q + 32'(mispredict);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            if_pc_q            <= RESET_PC;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if_pc_q            <= if_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Slot occupancy tracker; the bubble after a redirect lasts exactly one advance.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_EMPTY;
        end else if (enable) begin
            unique case (state_q)
                ST_EMPTY:   state_q <= ST_RUN;
                ST_RUN:     state_q <= mispredict ? ST_FLUSHED : ST_RUN;
                ST_FLUSHED: state_q <= ST_RUN;
                default:    state_q <= ST_EMPTY;
            endcase
        end
    end

    assign if_pc            = if_pc_q;
    assign flush            = mispredict;
    assign bp_update        = resolve;
    assign bp_branched      = id_taken;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed walk with literal expectations plus
// randomized traffic compared every cycle against a behavioural fetch/predict model.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        enable;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        id_is_branch;
    logic        id_taken;
    logic [63:0] id_target;
    logic [63:0] if_pc;
    logic [63:0] id_pc;
    logic        id_valid;
    logic        flush;
    logic        bp_update;
    logic        bp_branched;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: the fetch PC, what ID holds, and running statistics.
    logic [63:0] m_fetch_pc;
    logic [63:0] m_id_pc;
    logic        m_id_guess_taken;
    logic [63:0] m_id_guess_target;
    logic        m_id_live;
    int unsigned m_branches;
    int unsigned m_misses;

    next_pc_unit #(.PC_W(64), .INST_BYTES(4), .RESET_PC(64'h0)) dut (
        .clk              (clk),
        .arst             (arst),
        .enable           (enable),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .id_is_branch     (id_is_branch),
        .id_taken         (id_taken),
        .id_target        (id_target),
        .if_pc            (if_pc),
        .id_pc            (id_pc),
        .id_valid         (id_valid),
        .flush            (flush),
        .bp_update        (bp_update),
        .bp_branched      (bp_branched),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_branch_resolves();
        return m_id_live && id_is_branch && enable;
    endfunction

    // Wrong if the direction guess was wrong, or it went the right way to the wrong place.
    function automatic bit m_guess_wrong();
        if (!m_branch_resolves()) return 1'b0;
        if (m_id_guess_taken != id_taken) return 1'b1;
        return id_taken && (m_id_guess_target != id_target);
    endfunction

    task automatic model_reset();
        m_fetch_pc        = 64'h0;
        m_id_pc           = 64'h0;
        m_id_guess_taken  = 1'b0;
        m_id_guess_target = 64'h0;
        m_id_live         = 1'b0;
        m_branches        = 0;
        m_misses          = 0;
    endtask

    task automatic model_advance();
        bit          wrong;
        logic [63:0] next_pc;
        if (!enable) return;
        wrong = m_guess_wrong();
        if (m_branch_resolves()) m_branches++;
        if (wrong) m_misses++;
        if (wrong)           next_pc = id_taken ? id_target : m_id_pc + 64'd4;
        else if (pred_taken) next_pc = pred_target;
        else                 next_pc = m_fetch_pc + 64'd4;
        m_id_pc           = m_fetch_pc;
        m_id_guess_taken  = pred_taken;
        m_id_guess_target = pred_target;
        m_id_live         = !wrong;
        m_fetch_pc        = next_pc;
    endtask

    task automatic compare_all();
        check("if_pc",            if_pc,            m_fetch_pc);
        check("id_pc",            id_pc,            m_id_pc);
        check("id_valid",         id_valid,         m_id_live);
        check("flush",            flush,            m_guess_wrong());
        check("bp_update",        bp_update,        m_branch_resolves());
        check("bp_branched",      bp_branched,      id_taken);
        check("branch_count",     branch_count,     64'(m_branches));
        check("mispredict_count", mispredict_count, 64'(m_misses));
    endtask

    task automatic drive(input logic en, input logic pt, input logic [63:0] ptgt,
                         input logic br, input logic tk, input logic [63:0] tgt);
        enable       = en;
        pred_taken   = pt;
        pred_target  = ptgt;
        id_is_branch = br;
        id_taken     = tk;
        id_target    = tgt;
        #1;
    endtask

    task automatic tick();
        compare_all();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        model_reset();
        check("rst_if_pc",     if_pc,            64'h0);
        check("rst_id_valid",  id_valid,         64'h0);
        check("rst_id_pc",     id_pc,            64'h0);
        check("rst_branches",  branch_count,     64'h0);
        check("rst_misses",    mispredict_count, 64'h0);
        check("rst_flush",     flush,            64'h0);
        check("rst_bp_update", bp_update,        64'h0);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        do_reset();

        // Sequential fetch after reset
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        check("seq_pc0", if_pc, 64'h0);
        check("seq_valid0", id_valid, 64'h0);
        tick();
        check("seq_pc4", if_pc, 64'h4);
        check("seq_valid1", id_valid, 64'h1);
        tick();
        check("seq_pc8", if_pc, 64'h8);

        // Correctly predicted taken branch
        drive(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 64'h0);
        tick();
        check("pred_target_pc", if_pc, 64'h100);
        drive(1'b1, 1'b1, 64'h20, 1'b1, 1'b1, 64'h100);
        check("good_flush", flush, 64'h0);
        check("good_update", bp_update, 64'h1);
        tick();
        check("good_bcount", branch_count, 64'h1);
        check("good_pc", if_pc, 64'h20);

        // Predicted not-taken, actually taken to 0x80
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h80);
        check("nt_flush", flush, 64'h1);
        tick();
        check("nt_redirect", if_pc, 64'h80);
        check("nt_bubble", id_valid, 64'h0);
        check("nt_mcount", mispredict_count, 64'h1);
        drive(1'b1, 1'b1, 64'h20, 1'b1, 1'b1, 64'h80);
        check("bubble_no_update", bp_update, 64'h0);
        tick();
        check("bubble_over", id_valid, 64'h1);

        // Predicted taken to 0x40, actually not taken; concurrent pred_taken loses
        drive(1'b1, 1'b1, 64'h40, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 64'h900, 1'b1, 1'b0, 64'h0);
        check("t_flush", flush, 64'h1);
        check("t_branched", bp_branched, 64'h0);
        tick();
        check("t_redirect", if_pc, 64'h24);
        check("t_mcount", mispredict_count, 64'h2);

        // Stall across a pending mispredict
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h200);
            check("stall_no_update", bp_update, 64'h0);
            tick();
            check("stall_pc", if_pc, 64'h28);
            check("stall_id_pc", id_pc, 64'h24);
            check("stall_bcount", branch_count, 64'h3);
        end
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h200);
        check("unstall_flush", flush, 64'h1);
        tick();
        check("unstall_pc", if_pc, 64'h200);
        check("unstall_bcount", branch_count, 64'h4);

        // PC wrap at the top of the address space
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
        tick();
        check("top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        check("wrap_pc", if_pc, 64'h0);
        tick();

        // Asynchronous reset mid-run
        do_reset();
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        check("post_rst_pc", if_pc, 64'h0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        en, pt, br, tk;
            logic [63:0] ptgt, tgt;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            en   = ($urandom_range(0, 7) != 0);
            pt   = $urandom_range(0, 1);
            ptgt = {$urandom, $urandom} & ~64'h3;
            br   = ($urandom_range(0, 2) != 0);
            tk   = $urandom_range(0, 1);
            tgt  = ($urandom_range(0, 2) != 0) ? m_id_guess_target : ({$urandom, $urandom} & ~64'h3);
            drive(en, pt, ptgt, br, tk, tgt);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
